clk_meter_sched: RTL and testbench

- Synthesizable, single-clock scheduler that measures the frequency of NUM asynchronous clocks one at a time, round-robin, using one shared gate counter.
- Each measured clock drives a divide-by-2 toggle flop in its own domain; the toggles enter this block on `tog_in`.
- The block synchronizes the selected toggle, counts its transitions over a fixed gate window of `aclk` cycles and reports one count per channel over a valid/ready handshake.
- It also flags channels whose frequency matches channel 0 within a tolerance. It is the hardware counterpart of the simulation-only clock checks, used in bring-up and status registers.

---
 rtl/clk_meter_sched.sv | 177 +++++++++++++++++
 tb/tb_clk_meter_sched.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_meter_sched.sv
// clk_meter_sched: round-robin frequency meter for NUM asynchronous clocks.
// Each channel's divide-by-2 toggle is synchronized, one channel is selected,
// and its transitions are counted over a GATE_CYCLES window of aclk. Results
// leave over a valid/ready handshake; same[] flags channels within TOL of ch0.
// Optional feature: define CLK_METER_STUCK_EN to drive per-channel zero-count
// flags on stuck[] (otherwise stuck is tied low).
module clk_meter_sched #(
    parameter int NUM         = 4,
    parameter int GATE_CYCLES = 1000,
    parameter int CNT_W       = 20,
    parameter int TOL         = 2,
    parameter int SETTLE      = 4
) (
    input  logic                    aclk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [NUM-1:0]          tog_in,
    output logic                    result_valid,
    input  logic                    result_ready,
    output logic [$clog2(NUM)-1:0]  result_chan,
    output logic [CNT_W-1:0]        result_count,
    output logic                    done,
    output logic [NUM-1:0]          same,
    output logic [NUM-1:0]          stuck
);

    localparam int CHAN_W  = $clog2(NUM);
    localparam int TMR_MAX = (GATE_CYCLES > SETTLE) ? GATE_CYCLES : SETTLE;
    localparam int TMR_W   = $clog2(TMR_MAX);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_GATE,
        S_REPORT
    } state_t;

    state_t              state;
    logic [CHAN_W-1:0]   chan;
    logic [TMR_W-1:0]    tmr;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_next;
    logic [CNT_W-1:0]    count0;
    logic [CNT_W-1:0]    diff;
    logic                in_tol;
    logic                same_new;
    logic [NUM-1:0]      sync1;
    logic [NUM-1:0]      sync2;
    logic [NUM-1:0]      hist;
    logic                trans;

    // Two-flop synchronizer per channel plus a history flop for edge detection.
    always_ff @(posedge aclk) begin
        // NOTE: the synchronizer is reset too, so a restart never counts a stale edge.
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            hist  <= '0;
        end else begin
            // NOTE: non-blocking assignments make each stage take the pre-edge value
            // of the previous one; blocking ones would collapse the chain into a wire.
            sync1 <= tog_in;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    assign trans = sync2[chan] ^ hist[chan];

    // Saturating increment of the gate counter on a selected-channel transition.
    always_comb begin
        // NOTE: default assignment first so every path drives cnt_next (no latch).
        cnt_next = cnt;
        if (trans && (cnt != {CNT_W{1'b1}})) begin
            cnt_next = cnt + CNT_W'(1);
        end
    end

    assign diff   = (result_count >= count0) ? (result_count - count0)
                                             : (count0 - result_count);
    assign in_tol = (diff <= CNT_W'(TOL));

`ifdef CLK_METER_STUCK_EN
    logic zero_cnt;
    logic handshake;

    assign zero_cnt  = (result_count == '0);
    assign handshake = result_valid && result_ready;
    assign same_new  = in_tol && !zero_cnt && !stuck[0];

    // Record which channel produced a zero count at its handshake.
    always_ff @(posedge aclk) begin
        if (rst) begin
            stuck <= '0;
        end else if (handshake) begin
            stuck[chan] <= zero_cnt;
        end
    end
`else
    assign same_new = in_tol;
    assign stuck    = '0;
`endif

    // Sweep scheduler: settle, gate, report, then advance to the next channel.
    always_ff @(posedge aclk) begin
        if (rst) begin
            state        <= S_IDLE;
            chan         <= '0;
            tmr          <= '0;
            cnt          <= '0;
            count0       <= '0;
            result_valid <= 1'b0;
            result_chan  <= '0;
            result_count <= '0;
            done         <= 1'b0;
            same         <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (enable) begin
                        state <= S_SETTLE;
                        chan  <= '0;
                        tmr   <= '0;
                        done  <= 1'b0;
                    end
                end
                S_SETTLE: begin
                    if (!enable) begin
                        state <= S_IDLE;
                    end else if (tmr == TMR_W'(SETTLE - 1)) begin
                        state <= S_GATE;
                        tmr   <= '0;
                        cnt   <= '0;
                    end else begin
                        tmr <= tmr + TMR_W'(1);
                    end
                end
                S_GATE: begin
                    if (!enable) begin
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt_next;
                        if (tmr == TMR_W'(GATE_CYCLES - 1)) begin
                            result_count <= cnt_next;
                            result_chan  <= chan;
                            result_valid <= 1'b1;
                            state        <= S_REPORT;
                        end else begin
                            tmr <= tmr + TMR_W'(1);
                        end
                    end
                end
                S_REPORT: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        if (chan == '0) begin
                            same[0] <= 1'b1;
                            count0  <= result_count;
                        end else begin
                            same[chan] <= same_new;
                        end
                        if (chan == CHAN_W'(NUM - 1)) begin
                            done <= 1'b1;
                            chan <= '0;
                        end else begin
                            chan <= chan + CHAN_W'(1);
                        end
                        tmr   <= '0;
                        state <= enable ? S_SETTLE : S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clk_meter_sched.sv
// tb_clk_meter_sched: randomized bench for clk_meter_sched with a window-based
// reference model. Toggles are driven on the falling edge of aclk so the model
// can count them exactly from the per-edge samples.
module tb_clk_meter_sched;

    localparam int NUM   = 4;
    localparam int GATE  = 40;
    localparam int CNT_W = 5;
    localparam int TOL   = 2;
    localparam int SET   = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;
    localparam int RING  = 128;

`ifdef CLK_METER_STUCK_EN
    localparam logic [3:0] EXP_STUCK_E = 4'b0010;
`else
    localparam logic [3:0] EXP_STUCK_E = 4'b0000;
`endif

    logic             aclk = 1'b0;
    logic             rst = 1'b1;
    logic             enable = 1'b0;
    logic [NUM-1:0]   tog_in = '0;
    logic             result_valid;
    logic             result_ready = 1'b0;
    logic [1:0]       result_chan;
    logic [CNT_W-1:0] result_count;
    logic             done;
    logic [NUM-1:0]   same;
    logic [NUM-1:0]   stuck;

    int n_chk = 0;
    int n_err = 0;

    clk_meter_sched #(
        .NUM(NUM), .GATE_CYCLES(GATE), .CNT_W(CNT_W), .TOL(TOL), .SETTLE(SET)
    ) dut (
        .aclk(aclk), .rst(rst), .enable(enable), .tog_in(tog_in),
        .result_valid(result_valid), .result_ready(result_ready),
        .result_chan(result_chan), .result_count(result_count),
        .done(done), .same(same), .stuck(stuck)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic bound_expired(input string name);
        n_chk++;
        n_err++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // ---------------- toggle generators ----------------
    // hp[i] > 0: flip every hp[i] cycles; 0: constant; -1: random flip each cycle.
    int hp  [NUM];
    int ctr [NUM];

    always @(negedge aclk) begin
        for (int i = 0; i < NUM; i++) begin
            if (hp[i] < 0) begin
                if ($urandom_range(1, 0) == 1) tog_in[i] = ~tog_in[i];
            end else if (hp[i] > 0) begin
                if (ctr[i] <= 0) begin
                    tog_in[i] = ~tog_in[i];
                    ctr[i] = hp[i] - 1;
                end else begin
                    ctr[i]--;
                end
            end
        end
    end

    // ---------------- reference model ----------------
    // A measurement started at edge e delivers its result after edge e+SET+GATE,
    // counting toggles between samples j and j+1 for j in [e+SET-2, e+SET+GATE-3].
    logic [NUM-1:0]   samp [RING];
    int               cyc = 0;
    int               win_start = 0;
    int               m_diff;
    bit               m_busy = 0;
    bit               m_valid = 0;
    bit               m_done = 0;
    logic [1:0]       m_chan = '0;
    logic [1:0]       m_rchan = '0;
    logic [CNT_W-1:0] m_rcount = '0;
    logic [CNT_W-1:0] m_count0 = '0;
    logic [NUM-1:0]   m_same = '0;
    logic [NUM-1:0]   m_stuck = '0;

    function automatic int window_count(input int start, input int ch);
        int n = 0;
        for (int j = start + SET - 2; j <= start + SET + GATE - 3; j++) begin
            if (samp[j % RING][ch] != samp[(j + 1) % RING][ch]) n++;
        end
        return (n > CMAX) ? CMAX : n;
    endfunction

    always @(posedge aclk) begin
        samp[cyc % RING] = tog_in;
        if (rst) begin
            m_busy = 0; m_valid = 0; m_done = 0; m_chan = '0; m_rchan = '0;
            m_rcount = '0; m_count0 = '0; m_same = '0; m_stuck = '0;
        end else if (m_valid) begin
            if (result_ready) begin
                m_valid = 0;
                if (m_chan == 0) begin
                    m_same[0] = 1'b1;
                    m_count0  = m_rcount;
                end else begin
                    m_diff = (int'(m_rcount) > int'(m_count0)) ? int'(m_rcount) - int'(m_count0)
                                                               : int'(m_count0) - int'(m_rcount);
                    m_same[m_chan] = (m_diff <= TOL);
`ifdef CLK_METER_STUCK_EN
                    if (m_rcount == 0 || m_stuck[0]) m_same[m_chan] = 1'b0;
`endif
                end
`ifdef CLK_METER_STUCK_EN
                m_stuck[m_chan] = (m_rcount == 0);
`endif
                if (m_chan == NUM - 1) begin
                    m_done = 1;
                    m_chan = '0;
                end else begin
                    m_chan = m_chan + 2'd1;
                end
                if (enable) begin
                    m_busy = 1;
                    win_start = cyc;
                end
            end
        end else if (m_busy) begin
            if (!enable) begin
                m_busy = 0;
            end else if (cyc == win_start + SET + GATE) begin
                m_busy   = 0;
                m_valid  = 1;
                m_rchan  = m_chan;
                m_rcount = CNT_W'(window_count(win_start, int'(m_chan)));
            end
        end else if (enable) begin
            m_busy = 1;
            win_start = cyc;
            m_chan = '0;
            m_done = 0;
        end
        cyc++;
    end

    // Compare the DUT against the model one time unit after every edge.
    always @(posedge aclk) begin
        #1;
        check("valid", result_valid, m_valid);
        if (m_valid) begin
            check("chan", result_chan, m_rchan);
            check("count", result_count, m_rcount);
        end
        check("done", done, m_done);
        check("same", same, m_same);
        check("stuck", stuck, m_stuck);
    end

    // ---------------- directed + random stimulus ----------------
    task automatic wait_result(input string name, output logic [1:0] ch, output logic [CNT_W-1:0] cn);
        bit got = 0;
        ch = 'x;
        cn = 'x;
        for (int k = 0; k < 400 && !got; k++) begin
            @(posedge aclk);
            #1;
            if (result_valid) begin
                got = 1;
                ch = result_chan;
                cn = result_count;
            end
        end
        if (!got) bound_expired(name);
    endtask

    logic [1:0]       r_ch;
    logic [CNT_W-1:0] r_cn;
    int               exp_a [NUM] = '{20, 20, 8, 31};
    int               exp_e [NUM] = '{20, 0, 8, 31};
    bit               hit;

    initial begin
        hp = '{2, 2, 5, 1};
        ctr = '{0, 0, 0, 0};
        repeat (3) @(negedge aclk);

        // Reset values
        @(posedge aclk);
        #1;
        check("rst_valid", result_valid, 1'b0);
        check("rst_chan", result_chan, 2'd0);
        check("rst_count", result_count, 5'd0);
        check("rst_done", done, 1'b0);
        check("rst_same", same, 4'b0);
        check("rst_stuck", stuck, 4'b0);

        // One sweep with ready tied high: 20, 20, 8, saturated 31
        @(negedge aclk);
        rst = 1'b0;
        enable = 1'b1;
        result_ready = 1'b1;
        for (int i = 0; i < NUM; i++) begin
            wait_result("sweep_a", r_ch, r_cn);
            check("sweep_a_chan", r_ch, i);
            check("sweep_a_count", r_cn, exp_a[i]);
        end
        @(posedge aclk);
        #1;
        check("sweep_a_done", done, 1'b1);
        check("sweep_a_same", same, 4'b0011);

        // Back-pressure: result held for 50 cycles
        @(negedge aclk);
        result_ready = 1'b0;
        wait_result("hold", r_ch, r_cn);
        repeat (50) begin
            @(posedge aclk);
            #1;
            check("hold_valid", result_valid, 1'b1);
        end
        check("hold_chan", result_chan, 2'd0);
        check("hold_count", result_count, 5'd20);
        @(negedge aclk);
        result_ready = 1'b1;

        // Drop enable in the middle of channel 2's gate window
        hit = 0;
        for (int k = 0; k < 2000 && !hit; k++) begin
            @(negedge aclk);
            if (m_busy && m_chan == 2 && (cyc - win_start) == SET + GATE / 2) hit = 1;
        end
        if (!hit) bound_expired("abort_wait");
        enable = 1'b0;
        repeat (10) @(posedge aclk);
        #1;
        check("abort_valid", result_valid, 1'b0);
        check("abort_done", done, 1'b1);
        check("abort_same", same, 4'b0011);
        @(negedge aclk);
        enable = 1'b1;
        @(posedge aclk);
        #1;
        check("restart_done", done, 1'b0);

        // Reset while a result is pending
        @(negedge aclk);
        result_ready = 1'b0;
        wait_result("rst_pending", r_ch, r_cn);
        @(negedge aclk);
        rst = 1'b1;
        @(posedge aclk);
        #1;
        check("midrst_valid", result_valid, 1'b0);
        check("midrst_chan", result_chan, 2'd0);
        check("midrst_count", result_count, 5'd0);
        check("midrst_done", done, 1'b0);
        check("midrst_same", same, 4'b0);
        check("midrst_stuck", stuck, 4'b0);

        // Sweep with channel 1 frozen
        @(negedge aclk);
        rst = 1'b0;
        hp[1] = 0;
        result_ready = 1'b1;
        for (int i = 0; i < NUM; i++) begin
            wait_result("sweep_e", r_ch, r_cn);
            check("sweep_e_chan", r_ch, i);
            check("sweep_e_count", r_cn, exp_e[i]);
        end
        @(posedge aclk);
        #1;
        check("sweep_e_done", done, 1'b1);
        check("sweep_e_same", same, 4'b0001);
        check("sweep_e_stuck", stuck, EXP_STUCK_E);

        // Randomized traffic: periods, back-pressure and enable drops
        for (int blk = 0; blk < 20; blk++) begin
            @(negedge aclk);
            for (int i = 0; i < NUM; i++) begin
                int r;
                r = $urandom_range(9, 0);
                hp[i] = (r == 0) ? 0 : (r >= 7) ? -1 : r;
            end
            repeat (200) begin
                @(negedge aclk);
                result_ready = ($urandom_range(3, 0) != 0);
                if ($urandom_range(299, 0) == 0) enable = 1'b0;
                else if (!enable && $urandom_range(7, 0) == 0) enable = 1'b1;
            end
        end

        @(negedge aclk);
        enable = 1'b0;
        result_ready = 1'b1;
        repeat (20) @(posedge aclk);
        #2;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        n_err++;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $fatal(1, "watchdog");
    end

endmodule
